// File: rtl/apb_xip_cache_pkg.sv
// Shared types and constants for the APB XIP read cache.
package apb_xip_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HIT_RSP    = 3'd1,
    ST_FWD_SETUP  = 3'd2,
    ST_FWD_ACCESS = 3'd3,
    ST_RSP        = 3'd4,
    ST_ERR_RSP    = 3'd5
  } state_t;

  localparam logic [31:0] FLASH_ADDR_START_DEF = 32'h3000_0000;
  localparam logic [31:0] FLASH_ADDR_END_DEF   = 32'h3fff_ffff;

  // Index width for a direct-mapped array of the given (power-of-two) size.
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/apb_xip_cache_if.sv
// APB3/4 bus bundle. Handshake: the master raises psel for one setup cycle
// with penable low, then holds psel, penable and all request fields stable
// until it samples pready high on a rising edge; that edge completes the
// transfer and prdata/pslverr are valid only in that cycle.
interface apb_xip_cache_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/apb_xip_cache_array.sv
// Direct-mapped word store: valid/tag/data, combinational lookup, one write port.
module apb_xip_cache_array
  import apb_xip_cache_pkg::*;
#(
  parameter int ENTRIES = 4,
  localparam int IW = idx_w(ENTRIES),
  localparam int TW = 30 - IW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] lookup_idx,
  input  logic [TW-1:0] lookup_tag,
  output logic          lookup_hit,
  output logic [31:0]   lookup_data,
  input  logic          fill,
  input  logic [IW-1:0] fill_idx,
  input  logic [TW-1:0] fill_tag,
  input  logic [31:0]   fill_data,
  input  logic          flush_all
);

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];

  assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign lookup_data = data_q[lookup_idx];

  // Valid bits: reset and flush_all clear everything and beat a same-cycle fill.
  always_ff @(posedge clock) begin
    if (reset || flush_all) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data payload; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/apb_xip_cache.sv
// APB read cache in front of the SPI bridge: flash-window reads may hit locally,
// everything else is forwarded, flash writes are answered with an error.
module apb_xip_cache
  import apb_xip_cache_pkg::*;
#(
  parameter logic [31:0] flash_addr_start = FLASH_ADDR_START_DEF,
  parameter logic [31:0] flash_addr_end   = FLASH_ADDR_END_DEF,
  parameter int          ENTRIES          = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  apb_xip_cache_if.slave         in_apb,
  apb_xip_cache_if.master        out_apb,
  output state_t                 dbg_state
);

  localparam int IW = idx_w(ENTRIES);
  localparam int TW = 30 - IW;

  state_t      state_q;
  logic        in_pready_q, in_pslverr_q;
  logic [31:0] in_prdata_q;
  logic        out_psel_q, out_penable_q, out_pwrite_q;
  logic [31:0] out_paddr_q, out_pwdata_q;
  logic [2:0]  out_pprot_q;
  logic [3:0]  out_pstrb_q;
  logic        req_flash_q;

  logic        in_flash, lk_hit, fwd_done, fill, flush_all;
  logic [31:0] lk_data;

  assign in_flash  = (in_apb.paddr >= flash_addr_start) && (in_apb.paddr <= flash_addr_end);
  assign fwd_done  = (state_q == ST_FWD_ACCESS) && out_apb.pready;
  assign fill      = fwd_done && req_flash_q && !out_pwrite_q && !out_apb.pslverr;
  // A forwarded write could alias flash through the bridge, so drop everything.
  assign flush_all = flush || (fwd_done && out_pwrite_q);

  apb_xip_cache_array #(.ENTRIES(ENTRIES)) u_array (
    .clock       (clock),
    .reset       (reset),
    .lookup_idx  (in_apb.paddr[2 +: IW]),
    .lookup_tag  (in_apb.paddr[31:2+IW]),
    .lookup_hit  (lk_hit),
    .lookup_data (lk_data),
    .fill        (fill),
    .fill_idx    (out_paddr_q[2 +: IW]),
    .fill_tag    (out_paddr_q[31:2+IW]),
    .fill_data   (out_apb.prdata),
    .flush_all   (flush_all)
  );

  // Transfer FSM with all bus outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      in_pready_q   <= 1'b0;
      in_pslverr_q  <= 1'b0;
      in_prdata_q   <= '0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
      out_pwrite_q  <= 1'b0;
      out_paddr_q   <= '0;
      out_pwdata_q  <= '0;
      out_pprot_q   <= '0;
      out_pstrb_q   <= '0;
      req_flash_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_apb.psel && in_apb.penable) begin
            out_paddr_q  <= in_apb.paddr;
            out_pwrite_q <= in_apb.pwrite;
            out_pwdata_q <= in_apb.pwdata;
            out_pprot_q  <= in_apb.pprot;
            out_pstrb_q  <= in_apb.pstrb;
            req_flash_q  <= in_flash;
            if (in_flash && in_apb.pwrite) begin
              state_q      <= ST_ERR_RSP;
              in_pready_q  <= 1'b1;
              in_pslverr_q <= 1'b1;
              in_prdata_q  <= '0;
            end else if (in_flash && lk_hit) begin
              state_q      <= ST_HIT_RSP;
              in_pready_q  <= 1'b1;
              in_pslverr_q <= 1'b0;
              in_prdata_q  <= lk_data;
            end else begin
              state_q       <= ST_FWD_SETUP;
              out_psel_q    <= 1'b1;
              out_penable_q <= 1'b0;
            end
          end
        end
        ST_FWD_SETUP: begin
          out_penable_q <= 1'b1;
          state_q       <= ST_FWD_ACCESS;
        end
        ST_FWD_ACCESS: begin
          if (out_apb.pready) begin
            out_psel_q    <= 1'b0;
            out_penable_q <= 1'b0;
            in_pready_q   <= 1'b1;
            in_prdata_q   <= out_apb.prdata;
            in_pslverr_q  <= out_apb.pslverr;
            state_q       <= ST_RSP;
          end
        end
        ST_HIT_RSP, ST_RSP, ST_ERR_RSP: begin
          in_pready_q  <= 1'b0;
          in_pslverr_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_apb.pready    = in_pready_q;
  assign in_apb.prdata    = in_prdata_q;
  assign in_apb.pslverr   = in_pslverr_q;
  assign out_apb.psel     = out_psel_q;
  assign out_apb.penable  = out_penable_q;
  assign out_apb.paddr    = out_paddr_q;
  assign out_apb.pwrite   = out_pwrite_q;
  assign out_apb.pwdata   = out_pwdata_q;
  assign out_apb.pprot    = out_pprot_q;
  assign out_apb.pstrb    = out_pstrb_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_apb_xip_cache.sv
// Bench for apb_xip_cache: directed upstream transfers, a scripted downstream
// responder, and a per-cycle compare against a word-level cache model.
module tb_apb_xip_cache;
  import apb_xip_cache_pkg::*;

  localparam int ENTRIES = 4;
  localparam int K_HIT = 0, K_ERR = 1, K_FWD = 2;

  // ---------------- clock / reset ----------------
  logic   clock = 1'b0;
  logic   reset = 1'b1;
  logic   flush = 1'b0;
  state_t dbg_state;

  apb_xip_cache_if up ();
  apb_xip_cache_if dn ();

  apb_xip_cache #(
    .flash_addr_start (32'h3000_0000),
    .flash_addr_end   (32'h3fff_ffff),
    .ENTRIES          (ENTRIES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_apb    (up),
    .out_apb   (dn),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Cached words keyed by word address; direct mapping means one word per index.
  logic [31:0] mdl_data [logic [29:0]];

  // Expected outcome of the transfer in flight.
  int          exp_kind;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic        exp_err, exp_write;
  logic [3:0]  exp_strb;
  logic [2:0]  exp_prot;

  // Downstream responder script.
  int          rsp_wait = 0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err  = 1'b0;
  int          dn_xfers = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_flash(input logic [31:0] a);
    return (a >= 32'h3000_0000) && (a <= 32'h3fff_ffff);
  endfunction

  task automatic mdl_fill(input logic [31:0] a, input logic [31:0] d);
    logic [29:0] w;
    logic [29:0] victims[$];
    w = a[31:2];
    foreach (mdl_data[k]) if ((k % ENTRIES) == (w % ENTRIES)) victims.push_back(k);
    foreach (victims[i]) mdl_data.delete(victims[i]);
    mdl_data[w] = d;
  endtask

  // ---------------- downstream responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    dn.pready = 1'b0; dn.prdata = '0; dn.pslverr = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset || !(dn.psel && dn.penable) || dn.pready) begin
        dn.pready = 1'b0; dn.pslverr = 1'b0; cnt = 0;
      end else if (cnt == rsp_wait) begin
        dn.pready = 1'b1; dn.prdata = rsp_data; dn.pslverr = rsp_err;
        dn_xfers++;
      end else begin
        cnt++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare_loop();
    bit txn_on, b_seen, prev_rst;
    int cyc;
    txn_on = 0; b_seen = 0; prev_rst = 0; cyc = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        txn_on = 0; b_seen = 0; prev_rst = 1;
      end else begin
        if (prev_rst) begin
          check("rst_in_pready",   up.pready, 0);
          check("rst_in_pslverr",  up.pslverr, 0);
          check("rst_in_prdata",   up.prdata, 0);
          check("rst_out_psel",    dn.psel, 0);
          check("rst_out_penable", dn.penable, 0);
          check("rst_out_pwrite",  dn.pwrite, 0);
          check("rst_out_paddr",   dn.paddr, 0);
          check("rst_out_pwdata",  dn.pwdata, 0);
          check("rst_out_pstrb",   dn.pstrb, 0);
          check("rst_out_pprot",   dn.pprot, 0);
          check("rst_state",       dbg_state, ST_IDLE);
          prev_rst = 0;
        end
        if (!txn_on) begin
          check("idle_in_pready", up.pready, 0);
          check("idle_out_psel",  dn.psel, 0);
          if (up.psel && up.penable) begin
            txn_on = 1; cyc = 0; b_seen = 0;
          end
        end else begin
          cyc++;
          if (exp_kind != K_FWD) begin
            check("local_in_pready",  up.pready, 1);
            check("local_in_prdata",  up.prdata, exp_rdata);
            check("local_in_pslverr", up.pslverr, exp_err);
            check("local_out_psel",   dn.psel, 0);
            txn_on = 0;
          end else if (cyc == 1) begin
            check("setup_out_psel",    dn.psel, 1);
            check("setup_out_penable", dn.penable, 0);
            check("setup_in_pready",   up.pready, 0);
            check("setup_out_paddr",   dn.paddr, exp_addr);
            check("setup_out_pwrite",  dn.pwrite, exp_write);
            check("setup_out_pwdata",  dn.pwdata, exp_wdata);
            check("setup_out_pstrb",   dn.pstrb, exp_strb);
            check("setup_out_pprot",   dn.pprot, exp_prot);
          end else if (!b_seen) begin
            check("access_out_psel",    dn.psel, 1);
            check("access_out_penable", dn.penable, 1);
            check("access_in_pready",   up.pready, 0);
            if (dn.pready) b_seen = 1;
            if (cyc > 120) begin
              check("access_timeout", cyc, 0);
              txn_on = 0;
            end
          end else begin
            check("rsp_in_pready",   up.pready, 1);
            check("rsp_in_prdata",   up.prdata, exp_rdata);
            check("rsp_in_pslverr",  up.pslverr, exp_err);
            check("rsp_out_psel",    dn.psel, 0);
            check("rsp_out_penable", dn.penable, 0);
            txn_on = 0;
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_expect(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                            input logic [31:0] rd, input bit er);
    exp_addr = a; exp_write = wr; exp_wdata = wd;
    exp_strb = wr ? 4'b0011 : 4'b0000;
    exp_prot = 3'b010;
    if (is_flash(a) && wr) begin
      exp_kind = K_ERR; exp_rdata = '0; exp_err = 1'b1;
    end else if (is_flash(a) && !wr && mdl_data.exists(a[31:2])) begin
      exp_kind = K_HIT; exp_rdata = mdl_data[a[31:2]]; exp_err = 1'b0;
    end else begin
      exp_kind = K_FWD; exp_rdata = rd; exp_err = er;
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input bit wr, input logic [31:0] wd);
    @(posedge clock); #1;
    up.paddr = a; up.pwrite = wr; up.pwdata = wd;
    up.pstrb = wr ? 4'b0011 : 4'b0000; up.pprot = 3'b010;
    up.psel = 1'b1; up.penable = 1'b0;
    @(posedge clock); #1;
    up.penable = 1'b1;
  endtask

  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                      input int wt, input logic [31:0] rd, input bit er, input bit flush_b,
                      output logic [31:0] got, output logic got_err, output int lat);
    int x0, n;
    x0 = dn_xfers;
    set_expect(a, wr, wd, rd, er);
    rsp_wait = wt; rsp_data = rd; rsp_err = er;
    drive_req(a, wr, wd);
    n = 0;
    do begin
      @(negedge clock);
      flush = flush_b && dn.psel && dn.penable && dn.pready;
      n++;
    end while (!up.pready && n < 150);
    if (!up.pready) check("xfer_timeout", n, 0);
    got = up.prdata; got_err = up.pslverr; lat = n - 1;
    check("dn_xfer_count", dn_xfers - x0, (exp_kind == K_FWD) ? 1 : 0);
    @(posedge clock); #1;
    up.psel = 1'b0; up.penable = 1'b0; flush = 1'b0;
    if (exp_kind == K_FWD) begin
      if (wr) mdl_data.delete();
      else if (is_flash(a) && !er) mdl_fill(a, rd);
    end
    if (flush_b) mdl_data.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got, a;
    logic        gerr;
    int          lat;
    logic [31:0] addrs [6];
    addrs = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008,
              32'h3000_000C, 32'h3000_0010, 32'h3000_001C};
    up.paddr = '0; up.psel = 1'b0; up.penable = 1'b0; up.pprot = '0;
    up.pwrite = 1'b0; up.pwdata = '0; up.pstrb = '0;
    fork compare_loop(); join_none
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Cold miss, 5 wait states: B = A+7, upstream ready at A+8.
    xfer(32'h3000_0010, 0, 0, 5, 32'hDEAD_BEEF, 0, 0, got, gerr, lat);
    check("t1_data", got, 32'hDEAD_BEEF);
    check("t1_lat", lat, 8);
    // Same word now hits with one wait state; responder data must be ignored.
    xfer(32'h3000_0010, 0, 0, 5, 32'h1111_1111, 0, 0, got, gerr, lat);
    check("t2_data", got, 32'hDEAD_BEEF);
    check("t2_lat", lat, 1);
    // 0x...20 shares index 0 and evicts 0x...10.
    xfer(32'h3000_0020, 0, 0, 0, 32'hCAFE_0020, 0, 0, got, gerr, lat);
    check("t3_lat", lat, 3);
    xfer(32'h3000_0010, 0, 0, 2, 32'h0BAD_F00D, 0, 0, got, gerr, lat);
    check("t4_data", got, 32'h0BAD_F00D);
    check("t4_lat", lat, 5);
    // Flash write is refused locally.
    xfer(32'h3000_0004, 1, 32'h1, 0, 0, 0, 0, got, gerr, lat);
    check("t5_err", gerr, 1);
    check("t5_lat", lat, 1);
    // Register write forwarded verbatim and invalidates the cache.
    xfer(32'h1000_1014, 1, 32'h1, 1, 0, 0, 0, got, gerr, lat);
    check("t6_lat", lat, 4);
    xfer(32'h3000_0010, 0, 0, 0, 32'h1234_5678, 0, 0, got, gerr, lat);
    check("t7_miss_lat", lat, 3);
    // Non-flash reads are never cached.
    xfer(32'h1000_0000, 0, 0, 1, 32'h0000_0055, 0, 0, got, gerr, lat);
    xfer(32'h1000_0000, 0, 0, 1, 32'h0000_0066, 0, 0, got, gerr, lat);
    check("t8_data", got, 32'h0000_0066);
    // Downstream error is passed up and not cached.
    xfer(32'h3000_0104, 0, 0, 0, 32'h0000_000E, 1, 0, got, gerr, lat);
    check("t9_err", gerr, 1);
    xfer(32'h3000_0104, 0, 0, 0, 32'h0000_000F, 0, 0, got, gerr, lat);
    check("t9_retry_lat", lat, 3);
    // Flush coincident with the fill wins; response still delivered.
    xfer(32'h3000_0040, 0, 0, 3, 32'h0000_00F1, 0, 1, got, gerr, lat);
    check("t10_data", got, 32'h0000_00F1);
    xfer(32'h3000_0040, 0, 0, 0, 32'h0000_00F2, 0, 0, got, gerr, lat);
    check("t10_reread_data", got, 32'h0000_00F2);
    check("t10_reread_lat", lat, 3);

    // Mixed reads over a few indices with random data and wait states.
    for (int i = 0; i < 16; i++) begin
      a = addrs[$urandom_range(0, 5)];
      xfer(a, 0, 0, $urandom_range(0, 3), $urandom, 0, 0, got, gerr, lat);
    end

    // Reset in the middle of a downstream access.
    xfer(32'h3000_0014, 0, 0, 0, 32'hA5A5_0014, 0, 0, got, gerr, lat);
    xfer(32'h3000_0014, 0, 0, 0, 32'h0, 0, 0, got, gerr, lat);
    check("t11_hit_lat", lat, 1);
    set_expect(32'h3000_0018, 0, 0, 32'h0, 0);
    rsp_wait = 40; rsp_data = 32'h0; rsp_err = 1'b0;
    drive_req(32'h3000_0018, 0, 0);
    repeat (3) @(negedge clock);
    check("t11_mid_penable", dn.penable, 1);
    @(posedge clock); #1;
    reset = 1'b1; up.psel = 1'b0; up.penable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    mdl_data.delete();
    @(negedge clock);
    check("t11_after_psel", dn.psel, 0);
    check("t11_after_pready", up.pready, 0);
    xfer(32'h3000_0014, 0, 0, 0, 32'h5A5A_0014, 0, 0, got, gerr, lat);
    check("t11_reread_lat", lat, 3);
    check("t11_reread_data", got, 32'h5A5A_0014);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_xip_cache.md
# apb_xip_cache

APB-to-APB read cache sitting directly upstream of the SPI APB bridge, between the CPU-side APB crossbar port and the bridge's `in_*` slave port. Flash-range (XIP) reads that hit a small direct-mapped word cache complete locally, avoiding the slow SPI transfer. Misses and all SPI-master register accesses are forwarded unchanged. Writes into the flash window are rejected with an error.

## Interface
- `flash_addr_start`, 32'h30000000, first byte address of the XIP window
- `flash_addr_end`, 32'h3fffffff, last byte address of the XIP window
- `ENTRIES`, 4, number of cached words; power of two, ≥2
- `clock`  in  1  single clock; every register samples on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_paddr`/`in_psel`/`in_penable`/`in_pprot`/`in_pwrite`/`in_pwdata`/`in_pstrb`  in  32/1/1/3/1/32/4  upstream APB slave request
- `in_pready`/`in_prdata`/`in_pslverr`  out  1/32/1  upstream APB slave response
- `out_paddr`/`out_psel`/`out_penable`/`out_pprot`/`out_pwrite`/`out_pwdata`/`out_pstrb`  out  32/1/1/3/1/32/4  downstream APB master request, to the SPI bridge
- `out_pready`/`out_prdata`/`out_pslverr`  in  1/32/1  downstream APB master response
- `flush`  in  1  single-cycle pulse; invalidates all entries

## Operation
- Address split on word address:
  - index = `paddr[2+IW-1:2]`, where IW = log2(ENTRIES)
  - tag = `paddr[31:2+IW]`
  - `paddr[1:0]` is ignored; always the full word is returned
- Each entry holds one valid bit, one tag and one 32-bit data word. All valid bits are cleared on reset and on `flush`.
- FSM states: IDLE, HIT_RSP, FWD_SETUP, FWD_ACCESS, RSP, ERR_RSP.
- Transitions from IDLE, taken only when `in_psel & in_penable`; the request fields are latched at that point:
  - flash read, valid and tag match → HIT_RSP
  - flash write → ERR_RSP; no downstream access is made
  - anything else (flash miss, or any non-flash read/write) → FWD_SETUP
- HIT_RSP:
  - drives `in_pready`=1 and `in_prdata`=entry data for one cycle
  - next state is IDLE
- FWD_SETUP:
  - drives `out_psel`=1, `out_penable`=0, with the latched request on the `out_*` fields
  - next state is FWD_ACCESS
- FWD_ACCESS:
  - holds `out_psel`=1, `out_penable`=1 until `out_pready`
  - on `out_pready`: captures `out_prdata` and `out_pslverr`, then goes to RSP
  - on a flash read without `out_pslverr`: the entry at the index is filled and its valid bit set
  - on any forwarded write: all entries are invalidated, conservatively
- RSP:
  - drives `in_pready`=1 with the captured data and error for one cycle
  - next state is IDLE
- ERR_RSP:
  - drives `in_pready`=1, `in_pslverr`=1 and `in_prdata`=0 for one cycle
  - next state is IDLE
- `flush` coincident with a fill: the flush wins and the entry ends invalid. The in-flight response is still returned normally.
- A response-completing cycle leaves the FSM in IDLE. APB guarantees the next request shows `in_penable`=0 for at least one cycle, so a completed transfer is never re-accepted.

## Timing
- Reset values:
  - `in_pready`, `in_pslverr`, `out_psel`, `out_penable`, `out_pwrite` = 0
  - `in_prdata`, `out_paddr`, `out_pwdata` = 0
  - `out_pstrb` = 0, `out_pprot` = 0
  - state = IDLE, all entries invalid
- All outputs are registered or decoded from state only; there is no combinational path from `in_*` to `out_*`.
- Cycle A is the first cycle with `in_psel & in_penable` high.
- Hit: `in_pready` is high in cycle A+1, i.e. one wait state.
- Miss or forward:
  - `out_psel` rises in A+1 and `out_penable` in A+2
  - if `out_pready` is first seen high in cycle B, `in_pready` is high in B+1
  - `out_psel`/`out_penable` are low in B+1
- Flash-write error: `in_pready`=`in_pslverr`=1 in A+1.
- Reset asserted mid-transfer: in the next cycle all outputs take their reset values and the cache is invalid.
  - The downstream transfer is abandoned.
  - Upstream sees no `in_pready` for the aborted request.
- Fill and lookup never overlap, since the FSM serialises them; no bypass logic is needed.

## Structure
- Package `apb_xip_cache_pkg`:
  - FSM state enum
  - default `flash_addr_start`/`flash_addr_end` constants
  - `function idx_w(ENTRIES)`
- Sub-module `apb_xip_cache_array`:
  - valid/tag/data storage
  - one combinational lookup port: index in; hit and data out
  - one synchronous write port with fill and flush_all
  - flush_all has priority over fill

## Test plan
- Reset, then read 0x30000010 with downstream returning 0xDEADBEEF after 5 wait cycles → `in_prdata`=0xDEADBEEF, exactly one downstream transfer, `in_pready` in B+1.
- Repeat the read of 0x30000010 → `in_pready` at A+1, data 0xDEADBEEF, `out_psel` stays 0.
- Read 0x30000020, which aliases index 0 with ENTRIES=4, then 0x30000010 again → two downstream misses; second returns a fresh value.
- Write 0x30000004 → `in_pslverr`=1 at A+1, `out_psel` never asserted; then write 0x10001014 with data 0x1 → forwarded verbatim; a subsequent read of 0x30000010 misses.
- Pulse `flush` during FWD_ACCESS of a flash miss → response still delivered; a re-read of the same address misses.
- Assert `reset` during FWD_ACCESS → next cycle `out_psel`=0, `in_pready`=0; a following read of a previously cached address misses.
